// File: rtl/stream_source_gen.sv
// Stream source: replays a preloaded token buffer on a ready/valid stream after a flush pulse.
// Optional macro STREAM_SRC_STALL_INJECT_EN adds LFSR-driven stall gaps (GAP state) between tokens.
module stream_source_gen #(
    parameter int                    DATA_WIDTH  = 17,
    parameter int                    DEPTH       = 2048,
    parameter logic [DATA_WIDTH-1:0] DONE_TOKEN  = 17'h10100,
    parameter int                    START_DELAY = 3,
    parameter logic [15:0]           LFSR_SEED   = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     cfg_wr_en,
    input  logic [$clog2(DEPTH)-1:0] cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0]    cfg_wr_data,
    input  logic [$clog2(DEPTH):0]   tx_size,
    input  logic [15:0]              done_limit,
    input  logic [3:0]               stall_mask,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     valid,
    input  logic                     ready,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   tx_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DCW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        STREAM,
`ifdef STREAM_SRC_STALL_INJECT_EN
        GAP,
`endif
        FIN
    } state_e;

    state_e                state_q, state_d;
    logic [DCW-1:0]        delay_q, delay_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [AW:0]           tx_count_q, tx_count_d;
    logic [15:0]           done_cnt_q, done_cnt_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  hit_done;
    logic                  stop;
    logic                  wr_ok;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef STREAM_SRC_STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  gap_q, gap_d;
    logic [3:0]  gap_len;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign gap_len = lfsr_q[3:0] & stall_mask;
`else
    localparam logic [15:0] seed_unused = LFSR_SEED;
    logic stall_mask_unused;
    assign stall_mask_unused = ^stall_mask;
`endif

    // The buffer may only change while no stream is being replayed.
    assign wr_ok = cfg_wr_en && ((state_q == IDLE) || (state_q == ARMED) || (state_q == FIN));

    // NOTE: the token buffer has no reset; clearing thousands of entries would only cost logic and
    // its contents are defined by config writes before any replay.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        delay_d    = delay_q;
        ptr_d      = ptr_q;
        tx_count_d = tx_count_q;
        done_cnt_d = done_cnt_q;
        done_d     = done_q;
        data_d     = data_q;
        valid_d    = valid_q;
        hit_done   = 1'b0;
        stop       = 1'b0;
`ifdef STREAM_SRC_STALL_INJECT_EN
        gap_d  = gap_q;
        lfsr_d = lfsr_q;
        if ((state_q == STREAM) || (state_q == GAP)) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = ARMED;
                end
            end

            ARMED: begin
                if (!flush) begin
                    state_d    = DELAY;
                    delay_d    = DCW'(START_DELAY);
                    tx_count_d = '0;
                    ptr_d      = '0;
                    done_cnt_d = '0;
                    done_d     = 1'b0;
                end
            end

            DELAY: begin
                if (flush) begin
                    state_d = ARMED;
                    valid_d = 1'b0;
                end else if (delay_q <= DCW'(1)) begin
                    if (tx_size == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        // ptr_q is zero here, so this presents the first buffer entry.
                        state_d = STREAM;
                        data_d  = mem[ptr_q];
                        valid_d = 1'b1;
                    end
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end

            STREAM: begin
                if (flush) begin
                    state_d = ARMED;
                    valid_d = 1'b0;
                end else if (valid_q && ready) begin
                    hit_done   = (data_q == DONE_TOKEN);
                    tx_count_d = tx_count_q + 1'b1;
                    ptr_d      = ptr_q + 1'b1;
                    if (hit_done) begin
                        done_cnt_d = done_cnt_q + 1'b1;
                    end
                    stop = (tx_count_d == tx_size) ||
                           ((done_limit != '0) && hit_done && (done_cnt_d == done_limit));
                    if (stop) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d = mem[ptr_d];
`ifdef STREAM_SRC_STALL_INJECT_EN
                        if (gap_len != 4'd0) begin
                            state_d = GAP;
                            valid_d = 1'b0;
                            gap_d   = gap_len;
                        end
`endif
                    end
                end
            end

`ifdef STREAM_SRC_STALL_INJECT_EN
            GAP: begin
                if (flush) begin
                    state_d = ARMED;
                    valid_d = 1'b0;
                end else if (gap_q <= 4'd1) begin
                    state_d = STREAM;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
`endif

            FIN: begin
                if (flush) begin
                    state_d = ARMED;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            delay_q    <= '0;
            ptr_q      <= '0;
            tx_count_q <= '0;
            done_cnt_q <= '0;
            done_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
`ifdef STREAM_SRC_STALL_INJECT_EN
            lfsr_q     <= LFSR_SEED;
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            ptr_q      <= ptr_d;
            tx_count_q <= tx_count_d;
            done_cnt_q <= done_cnt_d;
            done_q     <= done_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
`ifdef STREAM_SRC_STALL_INJECT_EN
            lfsr_q     <= lfsr_d;
            gap_q      <= gap_d;
`endif
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign done     = done_q;
    assign tx_count = tx_count_q;

endmodule
